// File: rtl/register_file.sv
// RV32I integer register file: 31 storage slots (x1..x31), x0 hardwired to zero,
// two combinational read ports and one clocked write port with no read bypass.

module register_file_slot (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        we,
  input  logic [31:0] d,
  output logic [31:0] q
);
  always_ff @(posedge Clk) begin
    if (!Rst)    q <= '0;
    else if (we) q <= d;
  end
endmodule

module register_file (
  input  logic [4:0]  RS1Sel,
  input  logic [4:0]  RS2Sel,
  input  logic [4:0]  RDSel,
  input  logic        wen,
  output logic [31:0] RS1Dat,
  output logic [31:0] RS2Dat,
  input  logic [31:0] RDDat,
  input  logic        Clk,
  input  logic        Rst
);
  localparam int NUM_REGS = 32;
  localparam int DAT_W    = 32;

  logic [NUM_REGS-1:0][DAT_W-1:0] regs;

  // Slot 0 has no storage; tying it to zero lets reads index regs directly.
  assign regs[0] = '0;

  genvar i;
  generate
    for (i = 1; i < NUM_REGS; i++) begin : g_slot
      localparam logic [4:0] IDX = 5'(i);
      register_file_slot u_slot (
        .Clk (Clk),
        .Rst (Rst),
        .we  (wen && (RDSel == IDX)),
        .d   (RDDat),
        .q   (regs[i])
      );
    end
  endgenerate

  assign RS1Dat = regs[RS1Sel];
  assign RS2Dat = regs[RS2Sel];
endmodule

// File: tb/tb_register_file.sv
// Directed bench for register_file: reset, x0 immutability, write enable,
// reset priority, full sweep and read-during-write ordering.

module tb_register_file;
  logic [4:0]  RS1Sel, RS2Sel, RDSel;
  logic        wen;
  logic [31:0] RS1Dat, RS2Dat, RDDat;
  logic        Clk, Rst;

  int checks = 0;
  int errors = 0;

  register_file dut (
    .RS1Sel (RS1Sel),
    .RS2Sel (RS2Sel),
    .RDSel  (RDSel),
    .wen    (wen),
    .RS1Dat (RS1Dat),
    .RS2Dat (RS2Dat),
    .RDDat  (RDDat),
    .Clk    (Clk),
    .Rst    (Rst)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance past one rising edge; inputs are then driven 1ns after the edge.
  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  initial begin
    logic [31:0] exp_v;
    Rst = 1'b0; wen = 1'b0; RDSel = '0; RDDat = '0; RS1Sel = '0; RS2Sel = '0;
    #1;
    check("x0_before_reset", RS1Dat, 32'h0);

    // Reset held for two edges
    tick(); tick();
    Rst = 1'b1;
    RS1Sel = 5'd1; RS2Sel = 5'd31; #1;
    check("reset_x1", RS1Dat, 32'h0);
    check("reset_x31", RS2Dat, 32'h0);

    // Basic write/read
    RDSel = 5'd2; RDDat = 32'hFFFF_FFCF; wen = 1'b1;
    tick();
    wen = 1'b0;
    RS1Sel = 5'd0; RS2Sel = 5'd2; #1;
    check("basic_x0", RS1Dat, 32'h0);
    check("basic_x2", RS2Dat, 32'hFFFF_FFCF);

    // x0 immutability
    RDSel = 5'd0; RDDat = 32'hFFFC_FFFC; wen = 1'b1;
    tick(); tick(); tick();
    wen = 1'b0;
    RS1Sel = 5'd0; RS2Sel = 5'd0; #1;
    check("x0_port1", RS1Dat, 32'h0);
    check("x0_port2", RS2Dat, 32'h0);
    RS2Sel = 5'd2; #1;
    check("x0_wr_x2_kept", RS2Dat, 32'hFFFF_FFCF);

    // Write disabled
    RDSel = 5'd2; RDDat = 32'h1234_5678; wen = 1'b0;
    tick(); tick();
    check("wen0_x2", RS2Dat, 32'hFFFF_FFCF);

    // wen pulsed between edges must not commit
    wen = 1'b1; #2; wen = 1'b0;
    tick();
    check("wen_glitch_x2", RS2Dat, 32'hFFFF_FFCF);

    // Preload x5 so the reset-priority clear is observable
    RDSel = 5'd5; RDDat = 32'h1111_1111; wen = 1'b1;
    tick();
    wen = 1'b0;
    RS1Sel = 5'd5; #1;
    check("preload_x5", RS1Dat, 32'h1111_1111);

    // Reset wins over a simultaneous write
    Rst = 1'b0; wen = 1'b1; RDSel = 5'd5; RDDat = 32'hA5A5_A5A5;
    tick();
    Rst = 1'b1; wen = 1'b0; #1;
    check("rstprio_x5", RS1Dat, 32'h0);
    check("rstprio_x2", RS2Dat, 32'h0);

    // Writes resume on first edge with Rst high
    wen = 1'b1;
    tick();
    wen = 1'b0; #1;
    check("resume_x5", RS1Dat, 32'hA5A5_A5A5);

    // Sweep x1..x31
    for (int i = 1; i < 32; i++) begin
      RDSel = 5'(i); RDDat = 32'(i) * 32'h0101_0101; wen = 1'b1;
      tick();
    end
    wen = 1'b0;
    for (int i = 1; i < 32; i++) begin
      RS1Sel = 5'(i); RS2Sel = 5'(32 - i); #1;
      check("sweep_p1", RS1Dat, 32'(i) * 32'h0101_0101);
      check("sweep_p2", RS2Dat, 32'(32 - i) * 32'h0101_0101);
    end
    RS1Sel = 5'd17; RS2Sel = 5'd17; #1;
    check("same_idx_p1", RS1Dat, 32'h1111_1111);
    check("same_idx_p2", RS2Dat, 32'h1111_1111);

    // Read-during-write: old value before the edge, new value after
    RS1Sel = 5'd7; RS2Sel = 5'd8; RDSel = 5'd7; RDDat = 32'hDEAD_BEEF; wen = 1'b1; #1;
    check("rdw_before", RS1Dat, 32'h0707_0707);
    tick();
    wen = 1'b0;
    check("rdw_after", RS1Dat, 32'hDEAD_BEEF);
    check("rdw_neighbor", RS2Dat, 32'h0808_0808);

    // Last slot boundary write
    exp_v = 32'h8000_0001;
    RDSel = 5'd31; RDDat = exp_v; wen = 1'b1;
    tick();
    wen = 1'b0;
    RS2Sel = 5'd31; #1;
    check("x31_write", RS2Dat, exp_v);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/register_file.md
# register_file

32 × 32-bit general-purpose integer register file for the single-cycle RV32I core. Provides two combinational read ports for instruction source operands (rs1, rs2) and one clocked write port for the destination (rd). Register x0 is hardwired to zero. It sits between the instruction decoder (register selects) and the ALU/writeback path.

## Interface
- No parameters; data width fixed at 32 bits, address width fixed at 5 bits (32 registers).
- One clock; reset is synchronous and active-low. Port order below is the instantiation order: RS1Sel, RS2Sel, RDSel, wen, RS1Dat, RS2Dat, RDDat, Clk, Rst.
- Clk  input  1  clock; all state changes on rising edge.
- Rst  input  1  synchronous active-low reset; 0 at a rising edge clears all registers.
- RS1Sel  input  5  read port 1 register index.
- RS2Sel  input  5  read port 2 register index.
- RDSel  input  5  write port register index.
- wen  input  1  write enable, active-high, sampled at rising edge.
- RDDat  input  32  write data.
- RS1Dat  output  32  contents of register RS1Sel.
- RS2Dat  output  32  contents of register RS2Sel.

## Operation
- Storage: registers x1..x31, 32 bits each. x0 has no storage.
- Read: RS1Dat = (RS1Sel == 0) ? 0 : x[RS1Sel]; RS2Dat likewise. Purely combinational, no clock involvement.
- Both read ports independent; same index on both ports returns the same value.
- Write: at rising edge of Clk, if Rst == 1 and wen == 1 and RDSel != 0, x[RDSel] <= RDDat.
- Writes to x0 (RDSel == 0) are discarded; x0 always reads 0x00000000.
- wen == 0: no register changes regardless of RDSel/RDDat.
- Reset: at rising edge with Rst == 0, x1..x31 <= 0x00000000. Reset has priority over a simultaneous write (write dropped).
- Reset mid-operation: any edge with Rst low clears contents; writes resume on the first edge with Rst high.
- X/undriven select inputs are don't-care; no internal state other than the 31 data registers.

## Timing
- Read latency: zero cycles (combinational from selects and current register contents).
- Write latency: one edge; value visible on read ports immediately after the rising edge that commits it.
- Read-during-write to the same index: no bypass. Before the edge the read port shows the old value; after the edge it shows RDDat.
- Reset values: all outputs 0x00000000 after the first reset edge (every register cleared). Before any reset, contents of x1..x31 are undefined; x0 reads 0 at all times.
- Rst, wen, RDSel, RDDat are sampled only at rising edges; changes between edges have no effect on state.

## Test plan
- Reset: hold Rst=0 for ≥2 edges, then Rst=1; RS1Sel=1, RS2Sel=31 -> RS1Dat=RS2Dat=0x00000000.
- Basic write/read: Rst=1, RDSel=2, RDDat=0xFFFFFFCF, wen=1 for one edge, then wen=0; RS1Sel=0, RS2Sel=2 -> RS2Dat=0xFFFFFFCF, RS1Dat=0x00000000.
- x0 immutability: RDSel=0, RDDat=0xFFFCFFFC, wen=1 over several edges -> reads of index 0 remain 0x00000000; x2 still 0xFFFFFFCF.
- Write disable: wen=0, RDSel=2, RDDat=0x12345678 across edges -> x2 unchanged at 0xFFFFFFCF.
- Reset priority: Rst=0 and wen=1, RDSel=5, RDDat=0xA5A5A5A5 at same edge -> x5=0 and x2=0 afterward.
- Sweep and read-during-write: write x[i]=i*0x01010101 for i=1..31, read back on both ports; with RS1Sel=RDSel=7, RS1Dat shows old value before the edge and new value after.
